// File: rtl/cic_decim_param.sv
// cic_decim_param
// ---------------
// Parametrised N-stage CIC decimator (Hogenauer structure).
//   - N pipelined integrators run at the input-sample rate (advance only on val_in).
//   - An internal counter picks every R-th accepted sample.
//   - N pipelined combs (differential delay M) run at the decimated rate.
//   - The final comb result is reduced to WOUT bits by truncation (ROUND=0)
//     or by round-half-up (ROUND=1).
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   val_in   in   input-sample-valid strobe
//   i_data   in   [WIN-1:0]  signed input sample, used only when val_in=1
//   val_out  out  single-cycle output-valid pulse
//   o_data   out  [WOUT-1:0] signed decimated sample, held between pulses

module cic_decim_param #(
    parameter int WIN   = 16,
    parameter int N     = 3,
    parameter int R     = 8,
    parameter int M     = 1,
    parameter int WOUT  = 16,
    parameter int ROUND = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            val_in,
    input  logic [WIN-1:0]  i_data,
    output logic            val_out,
    output logic [WOUT-1:0] o_data
);

    localparam int WG   = N * $clog2(R * M);
    localparam int W    = WIN + WG;
    localparam int DROP = W - WOUT;
    localparam int CW   = $clog2(R);

    localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

    // Rounding constant 2^(DROP-1); zero when truncating or when nothing is
    // dropped, so one reduction expression serves every configuration.
    localparam logic [W:0] HALF =
        (ROUND != 0 && DROP > 0) ? ((W + 1)'(1) << (DROP > 0 ? DROP - 1 : 0)) : '0;

    logic [W-1:0]    int_q  [N];
    logic [W-1:0]    int_d  [N];
    logic [CW-1:0]   cnt_q, cnt_d;
    // comb_q[0] holds the captured integrator value; comb_q[k] is comb stage k.
    logic [W-1:0]    comb_q [N+1];
    logic [W-1:0]    comb_d [N+1];
    // tok_q[k] marks that comb_q[k] holds a fresh decimated sample.
    logic [N:0]      tok_q, tok_d;
    // dly_q[k-1] is the M-deep delay line feeding comb stage k.
    logic [W-1:0]    dly_q  [N][M];
    logic [W-1:0]    dly_d  [N][M];
    logic            val_out_q, val_out_d;
    logic [WOUT-1:0] o_data_q, o_data_d;

    // Integrators and decimation counter. Every integrator uses the pre-edge
    // value of its predecessor, which pipelines the adder chain.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            int_d[k] = int_q[k];
        end
        cnt_d     = cnt_q;
        comb_d[0] = comb_q[0];
        tok_d[0]  = 1'b0;
        if (val_in) begin
            int_d[0] = int_q[0] + {{WG{i_data[WIN-1]}}, i_data};
            for (int k = 1; k < N; k++) begin
                int_d[k] = int_q[k] + int_q[k-1];
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                comb_d[0] = int_q[N-1];
                tok_d[0]  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Comb pipeline. A stage only updates (and shifts its delay line) when
    // the stage before it presents a token, so each delay line spans exactly
    // M decimated samples regardless of how sparse the input is.
    always_comb begin
        for (int k = 1; k <= N; k++) begin
            comb_d[k] = comb_q[k];
            tok_d[k]  = tok_q[k-1];
            for (int j = 0; j < M; j++) begin
                dly_d[k-1][j] = dly_q[k-1][j];
            end
            if (tok_q[k-1]) begin
                comb_d[k]     = comb_q[k-1] - dly_q[k-1][M-1];
                dly_d[k-1][0] = comb_q[k-1];
                for (int j = 1; j < M; j++) begin
                    dly_d[k-1][j] = dly_q[k-1][j-1];
                end
            end
        end
    end

    // Output reduction. The sum is formed in W+1 bits so adding the rounding
    // constant to the largest positive comb value cannot wrap.
    always_comb begin
        val_out_d = tok_q[N];
        o_data_d  = o_data_q;
        if (tok_q[N]) begin
            o_data_d = WOUT'(({comb_q[N][W-1], comb_q[N]} + HALF) >> DROP);
        end
    end

    // State registers; reset discards partial decimation and in-flight tokens.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_q     <= '{default: '0};
            cnt_q     <= '0;
            comb_q    <= '{default: '0};
            tok_q     <= '0;
            dly_q     <= '{default: '{default: '0}};
            val_out_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            int_q     <= int_d;
            cnt_q     <= cnt_d;
            comb_q    <= comb_d;
            tok_q     <= tok_d;
            dly_q     <= dly_d;
            val_out_q <= val_out_d;
            o_data_q  <= o_data_d;
        end
    end

    assign val_out = val_out_q;
    assign o_data  = o_data_q;

endmodule
